// File: rtl/ts_touch_reader_if.sv
// Shared SPI bus plus request/grant handshake between the touch reader and the bus arbiter.
// The master side drives the SPI pins and the request; the slave side owns MISO and the grant.
interface ts_touch_reader_if;
   logic sclk;
   logic mosi;
   logic miso;
   logic csn;
   logic bus_req;
   logic bus_gnt;

   modport master (
      output sclk,
      output mosi,
      output csn,
      output bus_req,
      input  miso,
      input  bus_gnt
   );

   modport slave (
      input  sclk,
      input  mosi,
      input  csn,
      input  bus_req,
      output miso,
      output bus_gnt
   );
endinterface

// File: rtl/ts_touch_reader.sv
// XPT2046-style touch reader: polls the controller over the shared SPI bus (Z1, then X/Y on touch)
// and publishes each poll's result with a one-cycle strobe.
module ts_touch_reader #(
   parameter int          DIV         = 4,
   parameter int          POLL_CYCLES = 100000,
   parameter logic [11:0] Z_THRESH    = 12'd100,
   parameter int          CS_GAP      = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   ts_touch_reader_if.master spi,
   output logic              busy,
   output logic              sample_vld,
   output logic              touched,
   output logic [11:0]       x,
   output logic [11:0]       y,
   output logic [11:0]       z1
);

   typedef enum logic [2:0] {
      IDLE, WAIT, REQ, CS_SETUP, XFER, CS_HOLD, NEXT, DONE
   } state_t;

   localparam logic [31:0] POLL_LAST     = 32'(POLL_CYCLES - 1);
   localparam logic [31:0] SETUP_LAST    = 32'(CS_GAP - 1);
   localparam logic [31:0] RISE_AT       = 32'(DIV - 1);
   localparam logic [31:0] BIT_LAST      = 32'(2 * DIV - 1);
   localparam logic [31:0] HOLD_LOW_LAST = 32'(CS_GAP - 1);
   localparam logic [31:0] HOLD_LAST     = 32'(2 * CS_GAP - 2);

   state_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [4:0]  bit_q, bit_d;
   logic [1:0]  frame_q, frame_d;
   logic [7:0]  cmd_q, cmd_d;
   logic [11:0] shift_q, shift_d;
   logic [11:0] z1_res_q, z1_res_d;
   logic [11:0] x_res_q, x_res_d;
   logic        csn_q, csn_d;
   logic        sclk_q, sclk_d;
   logic        mosi_q, mosi_d;
   logic        bus_req_q, bus_req_d;
   logic        sample_vld_q, sample_vld_d;
   logic        touched_q, touched_d;
   logic [11:0] x_q, x_d;
   logic [11:0] y_q, y_d;
   logic [11:0] z1_q, z1_d;
   logic [7:0]  frame_cmd;
   logic        grant_lost;

   assign frame_cmd  = (frame_q == 2'd0) ? 8'hB0 : (frame_q == 2'd1) ? 8'hD0 : 8'h90;
   assign grant_lost = !spi.bus_gnt && (state_q inside {CS_SETUP, XFER, CS_HOLD, NEXT});

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      bit_d        = bit_q;
      frame_d      = frame_q;
      cmd_d        = cmd_q;
      shift_d      = shift_q;
      z1_res_d     = z1_res_q;
      x_res_d      = x_res_q;
      csn_d        = csn_q;
      sclk_d       = sclk_q;
      mosi_d       = mosi_q;
      bus_req_d    = bus_req_q;
      sample_vld_d = 1'b0;
      touched_d    = touched_q;
      x_d          = x_q;
      y_d          = y_q;
      z1_d         = z1_q;

      if (grant_lost) begin
         // Abandon the poll entirely; the retry goes through a full WAIT period again.
         state_d   = IDLE;
         cnt_d     = '0;
         csn_d     = 1'b1;
         sclk_d    = 1'b0;
         mosi_d    = 1'b0;
         bus_req_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (enable) begin
                  state_d = WAIT;
                  cnt_d   = '0;
               end
            end
            WAIT: begin
               if (cnt_q == POLL_LAST) begin
                  state_d   = REQ;
                  cnt_d     = '0;
                  bus_req_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 32'd1;
               end
            end
            REQ: begin
               if (spi.bus_gnt) begin
                  state_d = CS_SETUP;
                  cnt_d   = '0;
                  frame_d = 2'd0;
                  csn_d   = 1'b0;
               end
            end
            CS_SETUP: begin
               if (cnt_q == SETUP_LAST) begin
                  state_d = XFER;
                  cnt_d   = '0;
                  bit_d   = 5'd0;
                  mosi_d  = frame_cmd[7];
                  cmd_d   = {frame_cmd[6:0], 1'b0};
               end else begin
                  cnt_d = cnt_q + 32'd1;
               end
            end
            XFER: begin
               // The command register shifts in zeros, so bits 8..23 drive mosi low for free.
               if (cnt_q == RISE_AT) begin
                  sclk_d = 1'b1;
                  if (bit_q >= 5'd9 && bit_q <= 5'd20) begin
                     shift_d = {shift_q[10:0], spi.miso};
                  end
               end
               if (cnt_q == BIT_LAST) begin
                  sclk_d = 1'b0;
                  cnt_d  = '0;
                  if (bit_q == 5'd23) begin
                     state_d = CS_HOLD;
                     mosi_d  = 1'b0;
                  end else begin
                     bit_d  = bit_q + 5'd1;
                     mosi_d = cmd_q[7];
                     cmd_d  = {cmd_q[6:0], 1'b0};
                  end
               end else begin
                  cnt_d = cnt_q + 32'd1;
               end
            end
            CS_HOLD: begin
               // Low for CS_GAP cycles, then high; the NEXT cycle completes the deselect gap.
               if (cnt_q == HOLD_LOW_LAST) begin
                  csn_d = 1'b1;
               end
               if (cnt_q == HOLD_LAST) begin
                  state_d = NEXT;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 32'd1;
               end
            end
            NEXT: begin
               case (frame_q)
                  2'd0: begin
                     z1_res_d = shift_q;
                     if (shift_q < Z_THRESH) begin
                        state_d      = DONE;
                        bus_req_d    = 1'b0;
                        sample_vld_d = 1'b1;
                        touched_d    = 1'b0;
                        z1_d         = shift_q;
                     end else begin
                        state_d = CS_SETUP;
                        frame_d = 2'd1;
                        cnt_d   = '0;
                        csn_d   = 1'b0;
                     end
                  end
                  2'd1: begin
                     x_res_d = shift_q;
                     state_d = CS_SETUP;
                     frame_d = 2'd2;
                     cnt_d   = '0;
                     csn_d   = 1'b0;
                  end
                  default: begin
                     state_d      = DONE;
                     bus_req_d    = 1'b0;
                     sample_vld_d = 1'b1;
                     touched_d    = 1'b1;
                     z1_d         = z1_res_q;
                     x_d          = x_res_q;
                     y_d          = shift_q;
                  end
               endcase
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         bit_q        <= '0;
         frame_q      <= '0;
         cmd_q        <= '0;
         shift_q      <= '0;
         z1_res_q     <= '0;
         x_res_q      <= '0;
         csn_q        <= 1'b1;
         sclk_q       <= 1'b0;
         mosi_q       <= 1'b0;
         bus_req_q    <= 1'b0;
         sample_vld_q <= 1'b0;
         touched_q    <= 1'b0;
         x_q          <= '0;
         y_q          <= '0;
         z1_q         <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         frame_q      <= frame_d;
         cmd_q        <= cmd_d;
         shift_q      <= shift_d;
         z1_res_q     <= z1_res_d;
         x_res_q      <= x_res_d;
         csn_q        <= csn_d;
         sclk_q       <= sclk_d;
         mosi_q       <= mosi_d;
         bus_req_q    <= bus_req_d;
         sample_vld_q <= sample_vld_d;
         touched_q    <= touched_d;
         x_q          <= x_d;
         y_q          <= y_d;
         z1_q         <= z1_d;
      end
   end

   assign spi.csn     = csn_q;
   assign spi.sclk    = sclk_q;
   assign spi.mosi    = mosi_q;
   assign spi.bus_req = bus_req_q;
   assign busy        = (state_q != IDLE);
   assign sample_vld  = sample_vld_q;
   assign touched     = touched_q;
   assign x           = x_q;
   assign y           = y_q;
   assign z1          = z1_q;

endmodule
